// File: rtl/multicycle_ctrl_pkg.sv
// Shared state encoding and helpers for the multi-cycle control FSM.
package multicycle_ctrl_pkg;

  localparam logic CTRL_ENABLE  = 1'b1;
  localparam logic CTRL_DISABLE = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  // The cycle counter runs in every state except the two terminal ones.
  function automatic logic counts_cycles(state_t s);
    return (s != S_HALT) && (s != S_ERR);
  endfunction

  // States in which a memory ack is awaited and the wait timer runs.
  function automatic logic is_wait_state(state_t s);
    return (s == S_IF) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// Memory-ack wait timer: counts cycles spent waiting, flags the cycle in
// which the count would reach TIMEOUT without an ack.
module multicycle_ctrl_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;

  // Wait count: cleared outside a wait or on ack, bumped on each unacked cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  // This unacked cycle is the TIMEOUT-th one; an ack in it is handled upstream.
  assign o_expire = i_inc && (r_cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: IF/ID/EX/MEM/WB sequencing, memory
// handshakes with timeout, retired-instruction and cycle counters.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_is_halt,
  input  logic             dec_reg_we,
  input  logic             br_taken,
  output logic             ir_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] cycles
);

  state_t           r_state;
  state_t           w_next;
  logic             r_mem_st;
  logic             r_mem_ld;
  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] r_cycles;
  logic             w_wait;
  logic             w_ack;
  logic             w_expire;

  // Only the ack belonging to the current wait state counts.
  assign w_wait = is_wait_state(r_state);
  assign w_ack  = ((r_state == S_IF) && imem_ack) || ((r_state == S_MEM) && dmem_ack);

  multicycle_ctrl_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_wait || w_ack),
    .i_inc    (w_wait && !w_ack),
    .o_expire (w_expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; an ack always beats a simultaneous timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_IF;
      S_IF: begin
        if (imem_ack)      w_next = S_ID;
        else if (w_expire) w_next = S_ERR;
      end
      S_ID:   w_next = dec_is_halt ? S_HALT : S_EX;
      S_EX:   w_next = (dec_is_store || dec_is_load) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack)      w_next = r_mem_st ? S_IF : S_WB;
        else if (w_expire) w_next = S_ERR;
      end
      S_WB:   w_next = S_IF;
      default: w_next = r_state;
    endcase
  end

  // Outputs: requests from state, strobes additionally qualified by acks.
  always_comb begin
    imem_req = CTRL_DISABLE;
    dmem_req = CTRL_DISABLE;
    dmem_we  = CTRL_DISABLE;
    ir_we    = CTRL_DISABLE;
    rf_we    = CTRL_DISABLE;
    pc_we    = CTRL_DISABLE;
    pc_sel   = CTRL_DISABLE;
    halted   = CTRL_DISABLE;
    err      = CTRL_DISABLE;
    case (r_state)
      S_IF: begin
        imem_req = CTRL_ENABLE;
        ir_we    = imem_ack;
      end
      S_MEM: begin
        dmem_req = r_mem_st || r_mem_ld;
        dmem_we  = r_mem_st;
        if (dmem_ack && r_mem_st) begin
          pc_we  = CTRL_ENABLE;
          pc_sel = br_taken;
        end
      end
      S_WB: begin
        rf_we  = dec_reg_we;
        pc_we  = CTRL_ENABLE;
        pc_sel = br_taken;
      end
      S_HALT: halted = CTRL_ENABLE;
      S_ERR:  err    = CTRL_ENABLE;
      default: ;
    endcase
  end

  // Latch the memory access type in EX; a store/load conflict resolves to store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_st <= 1'b0;
      r_mem_ld <= 1'b0;
    end else if (r_state == S_EX) begin
      r_mem_st <= dec_is_store;
      r_mem_ld <= dec_is_load && !dec_is_store;
    end
  end

  // Free-running counters, wrap silently; cycles freeze in terminal states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycles  <= '0;
      r_instret <= '0;
    end else begin
      if (counts_cycles(r_state)) r_cycles  <= r_cycles + 1'b1;
      if (pc_we)                  r_instret <= r_instret + 1'b1;
    end
  end

  assign state   = r_state;
  assign instret = r_instret;
  assign cycles  = r_cycles;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle traces built
// from the instruction type and memory latencies, checked every cycle.
module tb_multicycle_ctrl;

  localparam int TO    = 4;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_ack = 1'b0, dmem_ack = 1'b0;
  logic dec_is_load = 1'b0, dec_is_store = 1'b0, dec_is_halt = 1'b0, dec_reg_we = 1'b0;
  logic br_taken = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel, halted, err;
  logic [2:0] state;
  logic [CNT_W-1:0] instret, cycles;

  multicycle_ctrl #(.TIMEOUT(TO), .TO_W(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_halt(dec_is_halt), .dec_reg_we(dec_reg_we), .br_taken(br_taken),
    .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .state(state), .halted(halted), .err(err),
    .instret(instret), .cycles(cycles)
  );

  always #5 clk = ~clk;

  // One cycle of expected behaviour: inputs to drive plus required outputs.
  typedef struct packed {
    logic [2:0] st;
    logic iack, dack, ld, sto, hlt, rwe, br;
    logic ireq, dreq, dwe, irwe, rfwe, pcwe, pcsel;
  } ent_t;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_LDST = 3, K_HALT = 4;

  ent_t q[$];
  int checks = 0;
  int errors = 0;
  int exp_cyc = 0;
  int exp_ret = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {state, imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel, halted, err};
  endfunction

  // Everything zero: reset / idle view.
  task automatic chk_zero(input string tag);
    chk({tag, "_outs"}, 32'(outs()), 32'd0);
    chk({tag, "_instret"}, instret, 32'd0);
    chk({tag, "_cycles"}, cycles, 32'd0);
  endtask

  // Entry with random stray acks (the DUT must ignore them in this state).
  function automatic ent_t mk(input logic [2:0] st, input logic ld, input logic sto,
                              input logic hlt, input logic rwe, input logic br);
    ent_t e = '0;
    e.st = st; e.ld = ld; e.sto = sto; e.hlt = hlt; e.rwe = rwe; e.br = br;
    e.iack = 1'($urandom_range(0, 1));
    e.dack = 1'($urandom_range(0, 1));
    return e;
  endfunction

  // Expected trace of one instruction: IF waits ia cycles, MEM waits da cycles.
  task automatic push_instr(input int kind, input int ia, input int da,
                            input logic rwe, input logic br);
    logic ld, sto, hlt;
    ent_t e;
    ld  = (kind == K_LD) || (kind == K_LDST);
    sto = (kind == K_ST) || (kind == K_LDST);
    hlt = (kind == K_HALT);
    for (int i = 0; i <= ia; i++) begin
      e = mk(3'd1, ld, sto, hlt, rwe, br);
      e.iack = (i == ia); e.ireq = 1'b1; e.irwe = (i == ia);
      q.push_back(e);
    end
    q.push_back(mk(3'd2, ld, sto, hlt, rwe, br));
    if (hlt) return;
    q.push_back(mk(3'd3, ld, sto, hlt, rwe, br));
    if (ld || sto) begin
      for (int j = 0; j <= da; j++) begin
        e = mk(3'd4, ld, sto, hlt, rwe, br);
        e.dack = (j == da); e.dreq = 1'b1; e.dwe = sto;
        if (sto && j == da) begin e.pcwe = 1'b1; e.pcsel = br; end
        q.push_back(e);
      end
    end
    if (!sto) begin
      e = mk(3'd5, ld, sto, hlt, rwe, br);
      e.rfwe = rwe; e.pcwe = 1'b1; e.pcsel = br;
      q.push_back(e);
    end
  endtask

  task automatic push_term(input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) q.push_back(mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic step(input ent_t e);
    @(negedge clk);
    imem_ack = e.iack; dmem_ack = e.dack;
    dec_is_load = e.ld; dec_is_store = e.sto; dec_is_halt = e.hlt;
    dec_reg_we = e.rwe; br_taken = e.br;
    #1;
    chk($sformatf("outs_st%0d", e.st), 32'(outs()),
        32'({e.st, e.ireq, e.dreq, e.dwe, e.irwe, e.rfwe, e.pcwe, e.pcsel,
             (e.st == 3'd6), (e.st == 3'd7)}));
    chk("instret", instret, 32'(exp_ret));
    chk("cycles", cycles, 32'(exp_cyc));
    if (e.st < 3'd6) exp_cyc++;
    if (e.pcwe) exp_ret++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n && q.size() > 0; i++) step(q.pop_front());
  endtask

  task automatic run_all();
    while (q.size() > 0) step(q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1 chk_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    #1 chk_zero("idle");
    exp_cyc = 1; exp_ret = 0;
  endtask

  initial begin
    ent_t e;
    do_reset();

    // ADDI, fetch ack one cycle after the request
    push_instr(K_ALU, 1, 0, 1'b1, 1'b0);
    // LW with a 3-cycle data wait (ack on the TIMEOUT-th cycle wins)
    push_instr(K_LD, 0, 3, 1'b1, 1'b0);
    // SW, immediate ack: retires from MEM, no WB
    push_instr(K_ST, 0, 0, 1'b1, 1'b0);
    // Taken branch
    push_instr(K_ALU, 0, 0, 1'b0, 1'b1);
    run_all();

    // Random instruction mix, including the illegal load+store encoding
    for (int n = 0; n < 10; n++)
      push_instr($urandom_range(0, 3), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    run_all();

    // Halt, then ten frozen cycles
    push_instr(K_HALT, 0, 0, 1'b0, 1'b0);
    push_term(3'd6, 10);
    run_all();

    // Fetch timeout: TIMEOUT unacked cycles, then error with a late ack ignored
    do_reset();
    for (int i = 0; i < TO; i++) begin
      e = mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      e.iack = 1'b0; e.ireq = 1'b1;
      q.push_back(e);
    end
    push_term(3'd7, 5);
    e = q[TO]; e.iack = 1'b1; q[TO] = e;
    run_all();

    // Recovery after reset
    do_reset();
    push_instr(K_ALU, 0, 0, 1'b1, 1'b0);
    run_all();

    // Reset in the middle of a data wait: request drops without a clock edge
    push_instr(K_LD, 0, 3, 1'b1, 1'b0);
    run_n(5);
    q.delete();
    @(negedge clk);
    dmem_ack = 1'b0;
    #1 chk("mem_req_before_rst", 32'(dmem_req), 32'd1);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    dmem_ack = 1'b1;
    rst = 1'b0;
    #1 chk_zero("post_rst_idle");
    exp_cyc = 1; exp_ret = 0;
    push_instr(K_ALU, 1, 0, 1'b1, 1'b0);
    e = q[0]; e.dack = 1'b1; q[0] = e;
    run_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
